// File: rtl/vehicle_cmd_pkg.sv
// Shared types for the vehicle command initiator: response status codes,
// FSM state encoding and the default result width.
package vehicle_cmd_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BAD_TGT = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/vehicle_cmd_initiator_timeout_ctr.sv
// WAIT-phase cycle counter: cleared on issue, counts while enabled and
// saturates at TIMEOUT_CYCLES-1, which is also the expiry threshold.
module cmd_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/vehicle_cmd_initiator.sv
// Initiator for the start/done/result command handshake: one command in flight,
// one-cycle start pulse, timed wait for done, registered response.
//
// Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. While
// rsp_valid is high the response fields do not change.
module vehicle_cmd_initiator
  import vehicle_cmd_pkg::*;
#(
  parameter int N_TARGETS      = 4,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TGT_W          = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [TGT_W-1:0]            cmd_target,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [TGT_W-1:0]            rsp_target,
  output logic [1:0]                  rsp_status,
  output logic [DATA_W-1:0]           rsp_result,
  output logic [N_TARGETS-1:0]        tgt_start,
  input  logic [N_TARGETS-1:0]        tgt_done,
  input  logic [N_TARGETS*DATA_W-1:0] tgt_result,
  output logic                        busy,
  output state_e                      dbg_state
);

  state_e            state_q, state_d;
  logic [TGT_W-1:0]  idx_q;
  logic              first_wait_q;
  logic [TGT_W-1:0]  rsp_target_q, rsp_target_d;
  status_e           rsp_status_q, rsp_status_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [DATA_W-1:0] sel_result;
  logic              sel_done;
  logic              load_rsp, ctr_clear, ctr_en, expired;
  logic              accept, bad_idx;

  assign accept  = (state_q == S_IDLE) && cmd_valid;
  assign bad_idx = int'(cmd_target) >= N_TARGETS;

  // Only the latched target's done/result are ever looked at.
  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    for (int i = 0; i < N_TARGETS; i++) begin
      if (idx_q == TGT_W'(i)) begin
        sel_done   = tgt_done[i];
        sel_result = tgt_result[i*DATA_W +: DATA_W];
      end
    end
  end

  cmd_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .expired(expired)
  );

  always_comb begin
    state_d      = state_q;
    load_rsp     = 1'b0;
    ctr_clear    = 1'b0;
    ctr_en       = 1'b0;
    rsp_target_d = idx_q;
    rsp_status_d = ST_OK;
    rsp_result_d = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (bad_idx) begin
            state_d      = S_RESP;
            load_rsp     = 1'b1;
            rsp_target_d = cmd_target;
            rsp_status_d = ST_BAD_TGT;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        ctr_clear = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        ctr_en = 1'b1;
        // done is stale on the first WAIT cycle; done beats a coincident timeout
        if (!first_wait_q && sel_done) begin
          state_d      = S_RESP;
          load_rsp     = 1'b1;
          rsp_result_d = sel_result;
        end else if (expired) begin
          state_d      = S_RESP;
          load_rsp     = 1'b1;
          rsp_status_d = ST_TIMEOUT;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      first_wait_q <= 1'b0;
      rsp_target_q <= '0;
      rsp_status_q <= ST_OK;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      first_wait_q <= (state_q == S_ISSUE);
      if (accept) idx_q <= cmd_target;
      if (load_rsp) begin
        rsp_target_q <= rsp_target_d;
        rsp_status_q <= rsp_status_d;
        rsp_result_q <= rsp_result_d;
      end
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign tgt_start  = (state_q == S_ISSUE) ? (N_TARGETS'(1) << idx_q) : '0;
  assign rsp_target = rsp_target_q;
  assign rsp_status = rsp_status_q;
  assign rsp_result = rsp_result_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vehicle_cmd_initiator.sv
// Bench for vehicle_cmd_initiator: behavioural targets with programmable latency,
// directed scenarios followed by randomized commands against a latency/status model.
module tb_vehicle_cmd_initiator;
  import vehicle_cmd_pkg::*;

  localparam int NT = 3;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int TW = 2;
  localparam int RW = 2 + TW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [TW-1:0]     cmd_target = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [TW-1:0]     rsp_target;
  logic [1:0]        rsp_status;
  logic [DW-1:0]     rsp_result;
  logic [NT-1:0]     tgt_start;
  logic [NT-1:0]     tgt_done;
  logic [NT*DW-1:0]  tgt_result;
  logic              busy;
  state_e            dbg_state;

  vehicle_cmd_initiator #(
    .N_TARGETS(NT), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .TGT_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_target(rsp_target),
    .rsp_status(rsp_status), .rsp_result(rsp_result),
    .tgt_start(tgt_start), .tgt_done(tgt_done), .tgt_result(tgt_result),
    .busy(busy), .dbg_state(dbg_state)
  );

  // target responders: lat = cycles from start to done visible (0 = never);
  // slow targets clear a stale done one edge after sampling start
  int            lat[NT]  = '{default: 0};
  bit            slow[NT] = '{default: 1'b0};
  logic [DW-1:0] val[NT]  = '{default: '0};

  for (genvar g = 0; g < NT; g++) begin : g_tgt
    logic          d  = 1'b0;
    logic          sd = 1'b0;
    int            r  = 0;
    logic [DW-1:0] v  = '0;
    always @(posedge clk) begin
      sd <= tgt_start[g];
      if (tgt_start[g]) begin
        r <= (lat[g] == 0) ? 0 : lat[g] - 1;
        if (!slow[g]) d <= 1'b0;
      end else begin
        if (slow[g] && sd) d <= 1'b0;
        if (r > 1) r <= r - 1;
        else if (r == 1) begin
          r <= 0;
          d <= 1'b1;
          v <= val[g];
        end
      end
    end
    assign tgt_done[g] = d;
    assign tgt_result[g*DW +: DW] = v;
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected {status, target, result} and cycles from acceptance edge to rsp_valid
  function automatic logic [RW-1:0] model(input int tgt, input int l, input logic [DW-1:0] v,
                                          output int n);
    logic [TW-1:0] t;
    t = TW'(tgt);
    if (tgt >= NT) begin
      n = 1;
      return {2'b10, t, {DW{1'b0}}};
    end
    if (l >= 2 && l <= TO) begin
      n = l + 2;
      return {2'b00, t, v};
    end
    n = TO + 2;
    return {2'b01, t, {DW{1'b0}}};
  endfunction

  // driver: one command end to end, holding rsp_ready low for 'hold' cycles
  task automatic run_cmd(input int tgt, input int l, input logic [DW-1:0] v, input bit sl,
                         input int hold);
    int n, exp_n, starts;
    logic [NT-1:0] start_seen;
    logic [RW-1:0] exp, got;
    if (tgt < NT) begin
      lat[tgt]  = l;
      val[tgt]  = v;
      slow[tgt] = sl;
    end
    exp_q.push_back(model(tgt, l, v, exp_n));
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_target = TW'(tgt);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    starts = 0;
    start_seen = '0;
    while (!rsp_valid && n < 40) begin
      if (tgt_start != '0) begin
        starts++;
        start_seen = tgt_start;
      end
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", n, exp_n);
    chk("start_pulses", starts, (tgt < NT) ? 1 : 0);
    if (tgt < NT) chk("start_onehot", start_seen, 1 << tgt);
    exp = exp_q.pop_front();
    got = {rsp_status, rsp_target, rsp_result};
    chk("rsp_fields", got, exp);
    for (int i = 0; i < hold; i++) begin
      cmd_valid  = 1'b1;
      cmd_target = TW'($urandom_range(0, NT - 1));
      @(negedge clk);
      chk("rsp_hold", {rsp_status, rsp_target, rsp_result}, exp);
      chk("cmd_ready_resp", {cmd_ready, rsp_valid, tgt_start}, {1'b0, 1'b1, {NT{1'b0}}});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("after_handshake", {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {cmd_ready, rsp_valid, tgt_start, busy, rsp_target, rsp_status, rsp_result, dbg_state},
        {1'b1, 1'b0, {NT{1'b0}}, 1'b0, {TW{1'b0}}, 2'b00, {DW{1'b0}}, S_IDLE});
  endtask

  initial begin
    int seen;
    // reset
    @(negedge clk);
    chk_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // nominal 3-cycle target
    run_cmd(2, 3, 32'hDEAD_BEEF, 1'b0, 0);
    // stale done held from a previous op, slow-clearing target
    run_cmd(1, 3, 32'hA5A5_0001, 1'b1, 0);
    run_cmd(1, 5, 32'h5A5A_0002, 1'b1, 0);
    run_cmd(1, 2, 32'h0000_1234, 1'b1, 0);
    // timeout and threshold boundaries
    run_cmd(0, 0, 32'h1111_1111, 1'b0, 0);
    run_cmd(0, TO, 32'h2222_2222, 1'b0, 0);
    run_cmd(0, TO + 1, 32'h3333_3333, 1'b0, 0);
    // bad target
    run_cmd(3, 0, 32'h0, 1'b0, 0);
    // backpressure with a pending second command
    run_cmd(2, 4, 32'hCAFE_F00D, 1'b0, 10);
    run_cmd(0, 6, 32'h0BAD_CAFE, 1'b0, 0);

    // reset mid-WAIT aborts the command
    lat[0] = 0;
    cmd_valid = 1'b1;
    cmd_target = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_in_wait", {busy, dbg_state}, {1'b1, S_WAIT});
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    chk_reset_outputs("reset_held");
    rst_n = 1'b1;
    seen = 0;
    repeat (TO + 4) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);
    chk("cmd_ready_post_reset", cmd_ready, 1);

    // randomized commands
    for (int k = 0; k < 30; k++) begin
      int t, l;
      t = $urandom_range(0, 3);
      l = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(2, TO + 4);
      run_cmd(t, l, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
